// File: rtl/pixel_config_pkg.sv
// Shared state encoding and fetch-condition helper for the pixel configuration serialiser.
package pixel_config_pkg;

    localparam logic [2:0] ST_IDLE_ENC     = 3'd0;
    localparam logic [2:0] ST_READ_ENC     = 3'd1;
    localparam logic [2:0] ST_LOAD_ENC     = 3'd2;
    localparam logic [2:0] ST_SHIFT_LO_ENC = 3'd3;
    localparam logic [2:0] ST_SHIFT_HI_ENC = 3'd4;
    localparam logic [2:0] ST_NEXT_ENC     = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE     = ST_IDLE_ENC,
        ST_READ     = ST_READ_ENC,
        ST_LOAD     = ST_LOAD_ENC,
        ST_SHIFT_LO = ST_SHIFT_LO_ENC,
        ST_SHIFT_HI = ST_SHIFT_HI_ENC,
        ST_NEXT     = ST_NEXT_ENC
    } state_t;

    // A new word may only be fetched when enabled, the FIFO has data and downstream is ready.
    function automatic logic fetch_ok(input logic start, input logic empty, input logic busy);
        return start & ~empty & ~busy;
    endfunction

endpackage

// File: rtl/pixel_config_shifter.sv
// Word holding register, bit counter and MSB/LSB-first bit selection for the serialiser.
module pixel_config_shifter
    import pixel_config_pkg::*;
#(
    parameter int DATA_WIDTH      = 15,
    parameter int SHIFT_DIRECTION = 1,
    parameter int CNT_WIDTH       = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  advance,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [CNT_WIDTH-1:0]  bit_cnt,
    output logic                  next_bit
);

    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    function automatic logic pick_bit(input logic [DATA_WIDTH-1:0] w,
                                      input logic [CNT_WIDTH-1:0]  c);
        logic b;
        b = 1'b0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (c == CNT_WIDTH'(i)) begin
                b = (SHIFT_DIRECTION != 0) ? w[DATA_WIDTH-1-i] : w[i];
            end
        end
        return b;
    endfunction

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (load) begin
            shreg_d = data_in;
            cnt_d   = '0;
        end else if (advance) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bit_cnt = cnt_q;
    // Looks at next-cycle word/count so the registered S_DATA lines up with SHIFT_LO.
    assign next_bit = pick_bit(shreg_d, cnt_d);

endmodule

// File: rtl/pixel_config_statemachine.sv
// FIFO-to-serial configuration shifter: reads one word, clocks it out on S_CLK/S_DATA.
// Optional macro PIXCFG_WORD_GAP_EN stretches the inter-word NEXT state to two cycles.
module pixel_config_statemachine
    import pixel_config_pkg::*;
#(
    parameter int DATA_WIDTH      = 15,
    parameter int SHIFT_DIRECTION = 1,
    parameter int CNT_WIDTH       = 4
) (
    input  logic                  CLK_IN,
    input  logic                  RESET,
    input  logic                  START,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  BUSY,
    input  logic                  EMPTY,
    output logic                  S_CLK,
    output logic                  S_DATA,
    output logic                  RD_FIFO
);

    state_t               state_q, state_d;
    logic                 s_clk_q, s_clk_d;
    logic                 s_data_q, s_data_d;
    logic                 rd_fifo_q, rd_fifo_d;
    logic [CNT_WIDTH-1:0] bit_cnt;
    logic                 next_bit;
    logic                 fetch;
`ifdef PIXCFG_WORD_GAP_EN
    logic                 gap_q, gap_d;
`endif

    assign fetch = fetch_ok(START, EMPTY, BUSY);

    pixel_config_shifter #(
        .DATA_WIDTH      (DATA_WIDTH),
        .SHIFT_DIRECTION (SHIFT_DIRECTION),
        .CNT_WIDTH       (CNT_WIDTH)
    ) u_shifter (
        .clk      (CLK_IN),
        .rst      (RESET),
        .load     (state_q == ST_LOAD),
        .advance  (state_q == ST_SHIFT_HI),
        .data_in  (DATA_IN),
        .bit_cnt  (bit_cnt),
        .next_bit (next_bit)
    );

    always_comb begin
        state_d = state_q;
`ifdef PIXCFG_WORD_GAP_EN
        gap_d   = 1'b0;
`endif
        case (state_q)
            ST_IDLE:     if (fetch) state_d = ST_READ;
            ST_READ:     state_d = ST_LOAD;
            ST_LOAD:     state_d = ST_SHIFT_LO;
            ST_SHIFT_LO: state_d = ST_SHIFT_HI;
            ST_SHIFT_HI: state_d = (bit_cnt < CNT_WIDTH'(DATA_WIDTH - 1)) ? ST_SHIFT_LO : ST_NEXT;
            ST_NEXT: begin
`ifdef PIXCFG_WORD_GAP_EN
                if (!gap_q) begin
                    gap_d   = 1'b1;
                    state_d = ST_NEXT;
                end else begin
                    state_d = fetch ? ST_READ : ST_IDLE;
                end
`else
                state_d = fetch ? ST_READ : ST_IDLE;
`endif
            end
            default:     state_d = ST_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        rd_fifo_d = (state_d == ST_READ);
        s_clk_d   = (state_d == ST_SHIFT_HI);
        case (state_d)
            ST_SHIFT_LO: s_data_d = next_bit;
            ST_SHIFT_HI: s_data_d = s_data_q;
            default:     s_data_d = 1'b0;
        endcase
    end

    always_ff @(posedge CLK_IN) begin
        if (RESET) begin
            state_q   <= ST_IDLE;
            s_clk_q   <= 1'b0;
            s_data_q  <= 1'b0;
            rd_fifo_q <= 1'b0;
`ifdef PIXCFG_WORD_GAP_EN
            gap_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            s_clk_q   <= s_clk_d;
            s_data_q  <= s_data_d;
            rd_fifo_q <= rd_fifo_d;
`ifdef PIXCFG_WORD_GAP_EN
            gap_q     <= gap_d;
`endif
        end
    end

    assign S_CLK   = s_clk_q;
    assign S_DATA  = s_data_q;
    assign RD_FIFO = rd_fifo_q;

endmodule

// File: tb/tb_pixel_config_statemachine.sv
// Self-checking bench: directed vector tables, multi-cycle corner sequences and a
// randomized run against a word-position reference model (both shift directions).
module tb_pixel_config_statemachine;

    localparam int DW = 15;
`ifdef PIXCFG_WORD_GAP_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 0;
`endif
    localparam int PERIOD = 3 + 2 * DW + GAP;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy = 1'b0;
    logic          empty = 1'b1;
    logic [DW-1:0] data_in = '0;
    logic          s_clk1, s_data1, rd1;
    logic          s_clk0, s_data0, rd0;

    int checks = 0;
    int errors = 0;

    // reference model: position inside the current word (-1 = idle) and latched word
    int            m_t = -1;
    logic [DW-1:0] m_w = '0;

    always #5 clk = ~clk;

    pixel_config_statemachine #(
        .DATA_WIDTH(DW), .SHIFT_DIRECTION(1), .CNT_WIDTH(4)
    ) u_dut_msb (
        .CLK_IN(clk), .RESET(rst), .START(start), .DATA_IN(data_in), .BUSY(busy),
        .EMPTY(empty), .S_CLK(s_clk1), .S_DATA(s_data1), .RD_FIFO(rd1)
    );

    pixel_config_statemachine #(
        .DATA_WIDTH(DW), .SHIFT_DIRECTION(0), .CNT_WIDTH(4)
    ) u_dut_lsb (
        .CLK_IN(clk), .RESET(rst), .START(start), .DATA_IN(data_in), .BUSY(busy),
        .EMPTY(empty), .S_CLK(s_clk0), .S_DATA(s_data0), .RD_FIFO(rd0)
    );

    typedef struct {
        logic rst, start, busy, empty;
        int   reps;
        logic e_rd, e_clk, e_d;
    } vec_t;

    typedef struct {
        logic [DW-1:0] word;
        logic [DW-1:0] exp_msb;
        logic [DW-1:0] exp_lsb;
    } word_vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, want);
        end
    endtask

    // One clock: advance the model on the edge, compare both DUTs 1 time unit later.
    task automatic step();
        bit   cond, in_shift;
        int   k;
        logic e_rd, e_clk, e_d1, e_d0;
        @(posedge clk);
        cond = start && !empty && !busy;
        if (rst) begin
            m_t = -1;
            m_w = '0;
        end else if (m_t == -1 || m_t == PERIOD - 1) begin
            m_t = cond ? 0 : -1;
        end else begin
            if (m_t == 1) m_w = data_in;
            m_t = m_t + 1;
        end
        in_shift = (m_t >= 2) && (m_t < 2 + 2 * DW);
        k        = in_shift ? (m_t - 2) / 2 : 0;
        e_rd     = (m_t == 0);
        e_clk    = in_shift && (((m_t - 2) % 2) == 1);
        e_d1     = in_shift ? m_w[DW-1-k] : 1'b0;
        e_d0     = in_shift ? m_w[k] : 1'b0;
        #1;
        check("model", {26'd0, rd1, s_clk1, s_data1, rd0, s_clk0, s_data0},
              {26'd0, e_rd, e_clk, e_d1, e_rd, e_clk, e_d0});
    endtask

    task automatic wait_rd(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3 * PERIOD; i++) begin
            step();
            if (rd1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic drain();
        start = 1'b0;
        repeat (PERIOD + 4) step();
    endtask

    task automatic capture_word(input logic [DW-1:0] word, input logic [DW-1:0] exp1,
                                input logic [DW-1:0] exp0);
        bit            ok;
        int            edges, extra_rd;
        logic          prev;
        logic [DW-1:0] g1, g0;
        edges = 0; extra_rd = 0; g1 = '0; g0 = '0;
        data_in = word; empty = 1'b0; busy = 1'b0; start = 1'b1;
        wait_rd(ok);
        check("word_rd_seen", {31'd0, ok}, 32'd1);
        start = 1'b0;
        prev  = s_clk1;
        for (int i = 0; i < 2 * DW + 8; i++) begin
            step();
            if (s_clk1 && !prev) begin
                edges++;
                g1 = {g1[DW-2:0], s_data1};
                g0 = {g0[DW-2:0], s_data0};
            end
            prev = s_clk1;
            if (rd1) extra_rd++;
        end
        check("word_edges", edges, DW);
        check("word_bits_msb", {17'd0, g1}, {17'd0, exp1});
        check("word_bits_lsb", {17'd0, g0}, {17'd0, exp0});
        check("word_single_rd", extra_rd, 0);
    endtask

    vec_t      tbl[11];
    word_vec_t words[5];

    initial begin
        bit   ok;
        int   edges, rd_cnt, lat;
        int   times[$];
        logic prev;

        // cycle vectors: {rst, start, busy, empty, reps, exp rd, exp s_clk, exp s_data(msb)}
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 2,  1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 20, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 5,  1'b0, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5,  1'b0, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5,  1'b0, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1,  1'b0, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1,  1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1,  1'b0, 1'b1, 1'b1};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1,  1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1,  1'b0, 1'b1, 1'b0};

        // {word, bits seen MSB-first build, bits seen LSB-first build}, first bit at left
        words[0] = '{15'b110100101011001, 15'b110100101011001, 15'b100110101001011};
        words[1] = '{15'h7FFF, 15'h7FFF, 15'h7FFF};
        words[2] = '{15'h0001, 15'h0001, 15'h4000};
        words[3] = '{15'h0003, 15'h0003, 15'h6000};
        words[4] = '{15'h4000, 15'h4000, 15'h0001};

        data_in = 15'h4000;
        for (int i = 0; i < 11; i++) begin
            for (int r = 0; r < tbl[i].reps; r++) begin
                rst = tbl[i].rst; start = tbl[i].start;
                busy = tbl[i].busy; empty = tbl[i].empty;
                step();
                check($sformatf("vec%0d_rd", i), {31'd0, rd1}, {31'd0, tbl[i].e_rd});
                check($sformatf("vec%0d_sclk", i), {31'd0, s_clk1}, {31'd0, tbl[i].e_clk});
                check($sformatf("vec%0d_sdata", i), {31'd0, s_data1}, {31'd0, tbl[i].e_d});
            end
        end
        drain();

        for (int i = 0; i < 5; i++) begin
            capture_word(words[i].word, words[i].exp_msb, words[i].exp_lsb);
            drain();
        end

        // back-to-back words: RD_FIFO period
        start = 1'b1; empty = 1'b0; busy = 1'b0;
        for (int c = 0; c < 5 * PERIOD + 5; c++) begin
            data_in = DW'($urandom);
            step();
            if (rd1) times.push_back(c);
        end
        check("period_pulses", times.size(), 6);
        for (int i = 1; i < times.size(); i++)
            check("period_gap", times[i] - times[i-1], PERIOD);
        drain();

        // BUSY raised mid-word must not cut the word short
        data_in = 15'h2B35; start = 1'b1; empty = 1'b0; busy = 1'b0;
        wait_rd(ok);
        check("busy_rd_seen", {31'd0, ok}, 32'd1);
        edges = 0; rd_cnt = 0; prev = s_clk1;
        for (int i = 0; i < PERIOD + 30; i++) begin
            if (i == 10) busy = 1'b1;
            step();
            if (s_clk1 && !prev) edges++;
            prev = s_clk1;
            if (rd1) rd_cnt++;
        end
        check("busy_word_edges", edges, DW);
        check("busy_hold_no_rd", rd_cnt, 0);
        busy = 1'b0; lat = -1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (rd1 && lat < 0) lat = i;
        end
        check("busy_release_rd", lat, 0);
        drain();

        // reset while S_CLK is high for bit 7, then a full restart
        data_in = 15'h7FFF; start = 1'b1; empty = 1'b0; busy = 1'b0;
        wait_rd(ok);
        check("rst_rd_seen", {31'd0, ok}, 32'd1);
        edges = 0; prev = s_clk1;
        for (int i = 0; i < 2 * DW + 4 && edges < 8; i++) begin
            step();
            if (s_clk1 && !prev) edges++;
            prev = s_clk1;
        end
        check("rst_pre_edges", edges, 8);
        check("rst_pre_sclk", {31'd0, s_clk1}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_sclk", {31'd0, s_clk1}, 32'd0);
        check("rst_sdata_msb", {31'd0, s_data1}, 32'd0);
        check("rst_sdata_lsb", {31'd0, s_data0}, 32'd0);
        check("rst_rd", {31'd0, rd1}, 32'd0);
        capture_word(15'h0003, 15'h0003, 15'h6000);
        drain();

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst     = ($urandom_range(0, 299) == 0);
            start   = ($urandom_range(0, 7) != 0);
            busy    = ($urandom_range(0, 4) == 0);
            empty   = ($urandom_range(0, 3) == 0);
            data_in = DW'($urandom);
            step();
        end
        rst = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_config_statemachine.md
PIXEL_CONFIG_STATEMACHINE -- requirements
Module: pixel_config_statemachine

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 15, meaning the bit width of one configuration word.
REQ-002 The block SHALL have parameter SHIFT_DIRECTION, default 1, meaning 1 = MSB first and 0 = LSB first.
REQ-003 The block SHALL have parameter CNT_WIDTH, default 4, meaning the bit-counter width; 2**CNT_WIDTH >= DATA_WIDTH is required.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset, named as below.
REQ-005 CLK_IN  input  1  sole clock; all logic on its rising edge.
REQ-006 RESET  input  1  synchronous, active-high reset.
REQ-007 START  input  1  level enable; words are fetched only while high.
REQ-008 DATA_IN  input  DATA_WIDTH  FIFO read data, valid the cycle after RD_FIFO (standard, non-FWFT FIFO).
REQ-009 BUSY  input  1  downstream hold-off; no new word starts while high.
REQ-010 EMPTY  input  1  FIFO empty flag.
REQ-011 S_CLK  output  1  serial clock, registered.
REQ-012 S_DATA  output  1  serial data, registered.
REQ-013 RD_FIFO  output  1  one-cycle FIFO read strobe, registered.

Function
REQ-014 The FSM SHALL have states IDLE, READ, LOAD, SHIFT_LO, SHIFT_HI and NEXT.
REQ-015 IDLE SHALL go to READ when START=1, EMPTY=0 and BUSY=0; otherwise it SHALL stay in IDLE.
REQ-016 READ SHALL assert RD_FIFO for exactly one cycle, then go to LOAD.
REQ-017 LOAD SHALL capture DATA_IN into the shift register, clear the bit counter and go to SHIFT_LO.
REQ-018 In SHIFT_LO, S_CLK SHALL be 0 and S_DATA SHALL present the current bit: bit DATA_WIDTH-1-cnt when SHIFT_DIRECTION=1, bit cnt when SHIFT_DIRECTION=0.
REQ-019 In SHIFT_HI, S_CLK SHALL be 1 and S_DATA SHALL hold its value, so data is stable around the rising S_CLK edge.
REQ-020 Leaving SHIFT_HI, the counter SHALL increment; it SHALL return to SHIFT_LO if cnt < DATA_WIDTH-1, otherwise go to NEXT.
REQ-021 NEXT SHALL drive S_CLK=0 and go to READ under the REQ-015 condition, otherwise to IDLE.
REQ-022 Each word SHALL take 3 + 2*DATA_WIDTH cycles (33 cycles for DATA_WIDTH=15).
REQ-023 START, BUSY and EMPTY SHALL be sampled only in IDLE and NEXT; changes during a word SHALL NOT abort it.
REQ-024 RD_FIFO SHALL never assert while EMPTY=1 is sampled in the deciding state.
REQ-025 In IDLE, S_CLK SHALL be 0 and S_DATA SHALL be 0.

Reset
REQ-026 RESET=1 at a clock edge SHALL force IDLE, S_CLK=0, S_DATA=0, RD_FIFO=0, counter=0 and shift register=0, including mid-word.
REQ-027 After reset is released, no RD_FIFO SHALL occur before the first edge at which the REQ-015 condition holds.

Configuration
REQ-028 With macro PIXCFG_WORD_GAP_EN defined, NEXT SHALL last 2 cycles (S_CLK=0, S_DATA=0), making each word take 4 + 2*DATA_WIDTH cycles.
REQ-029 Without PIXCFG_WORD_GAP_EN defined, NEXT SHALL last 1 cycle as in REQ-021.

Structure
REQ-030 Package pixel_config_pkg SHALL hold the state enumeration type and the state encoding constants.
REQ-031 Sub-module pixel_config_shifter SHALL hold the shift register, bit counter and direction select; the FSM stays in the top level.

Verification
REQ-032 Reset pulse, EMPTY=1, START=0 -> RD_FIFO, S_CLK and S_DATA stay 0 for 20 cycles.
REQ-033 DATA_IN=15'b110100101011001, EMPTY=0, START=1, SHIFT_DIRECTION=1 -> one RD_FIFO pulse, then 15 S_CLK rising edges carrying 1,1,0,1,0,0,1,0,1,0,1,1,0,0,1.
REQ-034 Same word with SHIFT_DIRECTION=0 -> bits on S_CLK rising edges are 1,0,0,1,1,0,1,0,1,0,0,1,0,1,1.
REQ-035 EMPTY held 0, START held 1 -> RD_FIFO pulses exactly every 33 cycles (every 34 with PIXCFG_WORD_GAP_EN).
REQ-036 BUSY=1 asserted mid-word -> the current word completes all 15 bits, the FSM holds in IDLE until BUSY=0, then RD_FIFO pulses.
REQ-037 RESET during bit 7 -> next cycle S_CLK=0, S_DATA=0, state IDLE; a restart re-reads the FIFO and sends a full word.
